// File: rtl/fifo_rd_ctrl_if.sv
// Read-side FIFO controller bus: synchronized write pointer, memory read port,
// published read pointer, status, the output stream, and debug state.
interface fifo_rd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);

    logic [ADDR_WIDTH:0]   sync_wptr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ren;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [ADDR_WIDTH:0]   rptr_gray;
    logic                  empty;
    logic [ADDR_WIDTH:0]   fifo_level;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [1:0]            dbg_occ;
    logic                  dbg_pend;

    // Output stream: a word transfers on a cycle where out_valid && out_ready;
    // while out_valid && !out_ready, out_data and out_valid hold steady.
    modport master (
        input  sync_wptr, mem_rdata, out_ready,
        output mem_ren, mem_raddr, rptr_gray, empty, fifo_level,
               out_data, out_valid, dbg_occ, dbg_pend
    );

    modport slave (
        output sync_wptr, mem_rdata, out_ready,
        input  mem_ren, mem_raddr, rptr_gray, empty, fifo_level,
               out_data, out_valid, dbg_occ, dbg_pend
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller: empty detection against the synchronized
// write pointer, credit-based memory reads and a 2-entry FWFT output buffer.
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic           CLK,
    input  logic           RST,
    fifo_rd_ctrl_if.master bus
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int PW         = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        OCC_0 = 2'd0,
        OCC_1 = 2'd1,
        OCC_2 = 2'd2
    } occ_t;

    occ_t                  occ_q, occ_d;
    logic [PW-1:0]         rptr_bin_q, rptr_gray_q, rptr_bin_inc, wptr_bin;
    logic                  pend_q;
    logic [DATA_WIDTH-1:0] e0_q, e1_q, e0_d, e1_d;
    logic                  empty, pop, push, issue;
    logic [2:0]            credit;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign wptr_bin     = gray2bin(bus.sync_wptr);
    assign empty        = (rptr_gray_q == bus.sync_wptr);
    assign pop          = (occ_q != OCC_0) && bus.out_ready;
    assign push         = pend_q;
    assign rptr_bin_inc = rptr_bin_q + PW'(1);

    // Slots already claimed after this cycle's pop; issuing only at <= 1
    // guarantees the in-flight word always has room when it lands.
    assign credit = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
    assign issue  = !empty && (credit <= 3'd1);

    always_comb begin
        occ_d = occ_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        case ({push, pop})
            2'b10: begin
                case (occ_q)
                    OCC_0: begin
                        e0_d  = bus.mem_rdata;
                        occ_d = OCC_1;
                    end
                    OCC_1: begin
                        e1_d  = bus.mem_rdata;
                        occ_d = OCC_2;
                    end
                    default: occ_d = occ_q;
                endcase
            end
            2'b01: begin
                e0_d  = e1_q;
                occ_d = (occ_q == OCC_2) ? OCC_1 : OCC_0;
            end
            2'b11: begin
                if (occ_q == OCC_1) begin
                    e0_d = bus.mem_rdata;
                end else begin
                    e0_d = e1_q;
                    e1_d = bus.mem_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rptr_bin_q  <= '0;
            rptr_gray_q <= '0;
            pend_q      <= 1'b0;
            occ_q       <= OCC_0;
            e0_q        <= '0;
            e1_q        <= '0;
        end else begin
            if (issue) begin
                rptr_bin_q  <= rptr_bin_inc;
                rptr_gray_q <= rptr_bin_inc ^ (rptr_bin_inc >> 1);
            end
            pend_q <= issue;
            occ_q  <= occ_d;
            e0_q   <= e0_d;
            e1_q   <= e1_d;
        end
    end

    assign bus.mem_ren    = issue;
    assign bus.mem_raddr  = rptr_bin_q[ADDR_WIDTH-1:0];
    assign bus.rptr_gray  = rptr_gray_q;
    assign bus.empty      = empty;
    assign bus.fifo_level = wptr_bin - rptr_bin_q;
    assign bus.out_data   = e0_q;
    assign bus.out_valid  = (occ_q != OCC_0);
    assign bus.dbg_occ    = occ_q;
    assign bus.dbg_pend   = pend_q;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: memory model, word-count reference model with an
// expected-data queue, directed scenarios then randomized traffic.
module tb_fifo_rd_ctrl;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int PW    = 4;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    fifo_rd_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    fifo_rd_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    // Synchronous memory: data appears the cycle after mem_ren.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;
    always @(posedge CLK) if (bus.mem_ren) rdata_q <= mem[bus.mem_raddr];
    assign bus.mem_rdata = rdata_q;

    int checks   = 0;
    int failures = 0;

    int            wcnt;
    int            m_rd;
    bit            m_pend;
    logic [DW-1:0] m_pend_data;
    logic [DW-1:0] m_buf[$];
    logic [DW-1:0] exp_q[$];
    logic [PW-1:0] prev_gray;
    int            ren_cnt;
    int            issue_idx;
    bit            track_raddr;
    int            written;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] gray(input int b);
        logic [PW-1:0] x;
        x = b[PW-1:0];
        return x ^ (x >> 1);
    endfunction

    task automatic write_word(input logic [DW-1:0] d);
        mem[wcnt % DEPTH] = d;
        exp_q.push_back(d);
        wcnt++;
        bus.sync_wptr = gray(wcnt);
    endtask

    task automatic try_writes(input int n);
        for (int i = 0; i < n; i++) begin
            if (wcnt - m_rd < DEPTH) write_word(DW'($urandom_range(0, 255)));
        end
    endtask

    // One clock cycle, entered at the falling edge with writes already applied.
    task automatic cycle(input bit rdy);
        int            lvl;
        bit            e_empty, e_valid, e_pop, e_issue;
        logic [DW-1:0] sb;
        bus.out_ready = rdy;
        #1;
        lvl     = wcnt - m_rd;
        e_empty = (lvl == 0);
        e_valid = (m_buf.size() > 0);
        e_pop   = e_valid && rdy;
        e_issue = !e_empty && (m_buf.size() + int'(m_pend) - int'(e_pop) <= 1);

        check("empty", bus.empty, e_empty);
        check("fifo_level", bus.fifo_level, lvl % 16);
        check("out_valid", bus.out_valid, e_valid);
        check("occ", bus.dbg_occ, m_buf.size());
        check("mem_ren", bus.mem_ren, e_issue);
        check("mem_raddr", bus.mem_raddr, m_rd % DEPTH);
        check("rptr_gray", bus.rptr_gray, gray(m_rd));
        if (e_valid) check("out_data", bus.out_data, m_buf[0]);
        if (bus.rptr_gray != prev_gray) begin
            check("gray_step", $countones(bus.rptr_gray ^ prev_gray), 1);
            prev_gray = bus.rptr_gray;
        end
        if (track_raddr && e_issue) begin
            check("wrap_raddr", bus.mem_raddr, issue_idx % DEPTH);
            issue_idx++;
        end
        if (bus.mem_ren) ren_cnt++;

        if (e_pop) begin
            void'(m_buf.pop_front());
            if (exp_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                sb = exp_q.pop_front();
                check("sb_data", bus.out_data, sb);
            end
        end
        if (m_pend) m_buf.push_back(m_pend_data);
        m_pend = e_issue;
        if (e_issue) begin
            m_pend_data = mem[m_rd % DEPTH];
            m_rd++;
        end
        @(negedge CLK);
    endtask

    // Asynchronous reset asserted mid-cycle, entered at the falling edge.
    task automatic do_reset();
        #2 RST = 1'b0;
        #1;
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_raddr", bus.mem_raddr, 0);
        check("rst_gray", bus.rptr_gray, 0);
        check("rst_occ", bus.dbg_occ, 0);
        bus.sync_wptr = '0;
        bus.out_ready = 1'b0;
        wcnt = 0;
        m_rd = 0;
        m_pend = 1'b0;
        m_buf.delete();
        exp_q.delete();
        prev_gray = '0;
        #1;
        check("rst_ren", bus.mem_ren, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_level", bus.fifo_level, 0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("post_empty", bus.empty, 1);
        check("post_level", bus.fifo_level, 0);
        check("post_ren", bus.mem_ren, 0);
        @(negedge CLK);
    endtask

    initial begin
        bus.sync_wptr = '0;
        bus.out_ready = 1'b0;
        wcnt = 0;
        m_rd = 0;
        m_pend = 1'b0;
        prev_gray = '0;
        ren_cnt = 0;
        issue_idx = 0;
        track_raddr = 1'b0;
        @(negedge CLK);
        do_reset();

        // Single word with known payload
        write_word(8'hA5);
        repeat (4) cycle(1'b1);
        check("single_gray", bus.rptr_gray, 1);
        check("single_empty", bus.empty, 1);

        // Eight-word stream at full rate
        do_reset();
        for (int i = 0; i < 8; i++) write_word(DW'($urandom_range(0, 255)));
        ren_cnt = 0;
        repeat (12) cycle(1'b1);
        check("stream_ren_cnt", ren_cnt, 8);
        check("stream_gray", bus.rptr_gray, 4'b1100);
        check("stream_drained", exp_q.size(), 0);

        // Backpressure with five words available
        do_reset();
        for (int i = 0; i < 5; i++) write_word(DW'($urandom_range(0, 255)));
        repeat (6) cycle(1'b0);
        check("bp_level", bus.fifo_level, 3);
        check("bp_occ", bus.dbg_occ, 2);
        check("bp_ren", bus.mem_ren, 0);
        repeat (8) cycle(1'b1);
        check("bp_drained", exp_q.size(), 0);

        // Twenty words through the eight-entry memory
        do_reset();
        track_raddr = 1'b1;
        issue_idx = 0;
        written = 0;
        repeat (40) begin
            for (int k = 0; k < 2; k++) begin
                if (written < 20 && wcnt - m_rd < DEPTH) begin
                    write_word(DW'($urandom_range(0, 255)));
                    written++;
                end
            end
            cycle(1'b1);
        end
        track_raddr = 1'b0;
        check("wrap_issues", issue_idx, 20);
        check("wrap_gray", bus.rptr_gray, 4'b0110);
        check("wrap_raddr_end", bus.mem_raddr, 4);
        check("wrap_drained", exp_q.size(), 0);

        // Randomized traffic with a reset landing mid-stream
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            try_writes($urandom_range(0, 2));
            cycle($urandom_range(0, 3) != 0);
        end
        repeat (20) cycle(1'b1);
        check("rand_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
